// File: rtl/count_capture.sv
// Input-capture stage: snapshots the counter on synchronised evt edges into a small FIFO
// read over valid/ready. Define COUNT_CAPTURE_BOTH_EDGES_EN to also capture falling edges (adds rd_edge).
module count_capture #(
    parameter int N           = 32,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N-1:0]               count,
    input  logic                       evt,
    input  logic                       arm,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [N-1:0]               rd_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    input  logic                       clr_ovf
`ifdef COUNT_CAPTURE_BOTH_EDGES_EN
    ,
    output logic                       rd_edge
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
`ifdef COUNT_CAPTURE_BOTH_EDGES_EN
    localparam int EW = N + 1;
`else
    localparam int EW = N;
`endif
    localparam logic [LW-1:0] LEVEL_ZERO = LW'(0);
    localparam logic [LW-1:0] LEVEL_ONE  = LW'(1);
    localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);
    localparam logic [PW-1:0] PTR_ONE    = PW'(1);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   hist_r;
    logic                   evt_s;
    logic                   rise_s;
    logic                   fall_s;
    logic                   cap_s;
    logic [EW-1:0]          entry_s;
    logic [EW-1:0]          rd_entry_s;
    logic                   full_s;
    logic                   pop_s;
    logic                   push_s;
    logic                   drop_s;
    logic [LW-1:0]          level_nxt_s;
    logic [EW-1:0]          mem_r [DEPTH];
    logic [PW-1:0]          wr_ptr_r;
    logic [PW-1:0]          rd_ptr_r;
    logic [LW-1:0]          level_r;
    logic                   rd_valid_r;
    logic                   ovf_r;

    // Edge detection, push/pop arbitration and next fill level.
    always_comb begin
        evt_s   = sync_r[SYNC_STAGES-1];
        rise_s  = evt_s & ~hist_r & arm;
`ifdef COUNT_CAPTURE_BOTH_EDGES_EN
        fall_s  = ~evt_s & hist_r & arm;
        entry_s = {rise_s, count};
`else
        fall_s  = 1'b0;
        entry_s = count;
`endif
        cap_s   = rise_s | fall_s;
        full_s  = (level_r == LEVEL_FULL);
        pop_s   = rd_valid_r & rd_ready;
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        push_s  = cap_s & (~full_s | pop_s);
        drop_s  = cap_s & full_s & ~pop_s;
        level_nxt_s = level_r;
        case ({push_s, pop_s})
            2'b10:   level_nxt_s = level_r + LEVEL_ONE;
            2'b01:   level_nxt_s = level_r - LEVEL_ONE;
            default: level_nxt_s = level_r;
        endcase
    end

    // Synchroniser chain and edge-history flop; history tracks evt_s regardless of arm.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_r <= {SYNC_STAGES{1'b0}};
            hist_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], evt};
            hist_r <= evt_s;
        end
    end

    // FIFO pointers, level, valid flag and sticky overflow (a drop wins over clr_ovf).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r   <= {PW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
            level_r    <= LEVEL_ZERO;
            rd_valid_r <= 1'b0;
            ovf_r      <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            level_r    <= level_nxt_s;
            rd_valid_r <= (level_nxt_s != LEVEL_ZERO);
            if (drop_s) begin
                ovf_r <= 1'b1;
            end else if (clr_ovf) begin
                ovf_r <= 1'b0;
            end
        end
    end

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= entry_s;
        end
    end

    assign rd_entry_s = mem_r[rd_ptr_r];
    assign rd_data    = rd_entry_s[N-1:0];
    assign rd_valid   = rd_valid_r;
    assign level      = level_r;
    assign overflow   = ovf_r;
`ifdef COUNT_CAPTURE_BOTH_EDGES_EN
    assign rd_edge    = rd_entry_s[N];
`endif

endmodule

// File: tb/tb_count_capture.sv
// Self-checking bench for count_capture: directed scenarios plus randomized traffic
// checked against an edge-history / queue reference model.
module tb_count_capture;

    localparam int N     = 32;
    localparam int DEPTH = 4;
    localparam int S     = 2;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [N-1:0]  count = '0;
    logic          evt = 1'b0;
    logic          arm = 1'b0;
    logic          rd_ready = 1'b0;
    logic          clr_ovf = 1'b0;
    logic          rd_valid;
    logic [N-1:0]  rd_data;
    logic [LW-1:0] level;
    logic          overflow;
`ifdef COUNT_CAPTURE_BOTH_EDGES_EN
    logic          rd_edge;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: evt level seen at each edge since reset, queued entries {edge, count}, overflow flag.
    bit           e_hist[$];
    logic [N:0]   mq[$];
    bit           m_ovf;

    count_capture #(.N(N), .DEPTH(DEPTH), .SYNC_STAGES(S)) dut (
        .clk(clk), .rst(rst), .count(count), .evt(evt), .arm(arm),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .level(level), .overflow(overflow), .clr_ovf(clr_ovf)
`ifdef COUNT_CAPTURE_BOTH_EDGES_EN
        , .rd_edge(rd_edge)
`endif
    );

    always #5 clk = ~clk;

    // One clock edge; the model applies the capture rule: at edge t a capture happens when evt
    // was high at edge t-S and low at edge t-S-1, storing the count seen at edge t.
    task automatic tick();
        int t;
        bit es, eh, rise, fall, full, pop, a, rr, clr;
        logic [N-1:0] c;
        t = e_hist.size();
        e_hist.push_back(evt);
        es = (t >= S) ? e_hist[t-S] : 1'b0;
        eh = (t >= S + 1) ? e_hist[t-S-1] : 1'b0;
        a = arm; rr = rd_ready; clr = clr_ovf; c = count;
        rise = es & !eh & a;
`ifdef COUNT_CAPTURE_BOTH_EDGES_EN
        fall = !es & eh & a;
`else
        fall = 1'b0;
`endif
        full = (mq.size() == DEPTH);
        pop  = (mq.size() > 0) && rr;
        @(posedge clk);
        #1;
        if (pop) void'(mq.pop_front());
        if ((rise || fall) && full && !pop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        if ((rise || fall) && (!full || pop)) mq.push_back({rise, c});
        count = count + 1;
    endtask

    task automatic do_reset(input logic evt_init);
        rst = 1'b0; evt = evt_init; arm = 1'b1; rd_ready = 1'b0; clr_ovf = 1'b0; count = 100;
        e_hist.delete(); mq.delete(); m_ovf = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic pulse(input int hi, input int lo);
        evt = 1'b1;
        repeat (hi) tick();
        evt = 1'b0;
        repeat (lo) tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (level !== '0) begin n_fail++; $display("FAIL reset_level got %0d want 0", level); end
        n_tests++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", rd_valid); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", overflow); end
        // evt held high through reset release counts as one rising edge
        do_reset(1'b1);
        repeat (S + 3) tick();
        n_tests++; if (level !== LW'(1)) begin n_fail++; $display("FAIL release_high_level got %0d want 1", level); end
        n_tests++; if (rd_data !== N'(100 + S)) begin n_fail++; $display("FAIL release_high_data got %0d want %0d", rd_data, 100 + S); end
        evt = 1'b0;
    endtask

    task automatic test_latency();
        int lat;
        logic [N-1:0] c0;
        do_reset(1'b0);
        repeat (3) tick();
        c0 = count;
        evt = 1'b1;
        lat = 0;
        for (int i = 1; i <= 12; i++) begin
            if (i == 6) evt = 1'b0;
            tick();
            if (rd_valid === 1'b1 && lat == 0) lat = i;
        end
        n_tests++; if (lat != S + 1) begin n_fail++; $display("FAIL latency got %0d edges want %0d", lat, S + 1); end
        n_tests++; if (rd_data !== c0 + N'(S)) begin n_fail++; $display("FAIL latency_data got %0d want %0d", rd_data, c0 + N'(S)); end
        n_tests++; if (level !== LW'(mq.size())) begin n_fail++; $display("FAIL latency_level got %0d want %0d", level, mq.size()); end
        rd_ready = 1'b1;
        while (mq.size() > 0) tick();
        rd_ready = 1'b0;
        n_tests++; if (level !== '0 || rd_valid !== 1'b0) begin n_fail++; $display("FAIL pop_empty got level %0d valid %b want 0 0", level, rd_valid); end
    endtask

    task automatic test_backpressure();
        logic [N-1:0] c0;
        do_reset(1'b0);
        repeat (2) tick();
        c0 = count + N'(S);
        repeat (3) pulse(5, 5);
        n_tests++; if (level !== LW'(mq.size())) begin n_fail++; $display("FAIL bp_level got %0d want %0d", level, mq.size()); end
        n_tests++; if (rd_data !== c0) begin n_fail++; $display("FAIL bp_head got %0d want %0d", rd_data, c0); end
        rd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_tests++; if (rd_data !== c0 + N'(10 * i)) begin n_fail++; $display("FAIL bp_order%0d got %0d want %0d", i, rd_data, c0 + N'(10 * i)); end
            tick();
        end
        rd_ready = 1'b0;
    endtask

    task automatic test_overflow();
        logic [N-1:0] first[$];
        do_reset(1'b0);
        repeat (2) tick();
        for (int i = 0; i < 5; i++) begin
            if (i < 4) first.push_back(count + N'(S));
            pulse(S + 2, S + 2);
        end
        n_tests++; if (level !== LW'(DEPTH)) begin n_fail++; $display("FAIL ovf_level got %0d want %0d", level, DEPTH); end
        n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b want 1", overflow); end
        rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_tests++; if (rd_data !== first[i]) begin n_fail++; $display("FAIL ovf_drain%0d got %0d want %0d", i, rd_data, first[i]); end
            tick();
        end
        rd_ready = 1'b0;
        n_tests++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_fifth_absent got valid %b want 0", rd_valid); end
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %b want 0", overflow); end
    endtask

    task automatic test_full_pop();
        logic [N-1:0] c_last, got;
        do_reset(1'b0);
        repeat (2) tick();
        repeat (4) pulse(S + 2, S + 2);
        evt = 1'b1;
        repeat (S) tick();
        c_last = count;
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        n_tests++; if (level !== LW'(DEPTH)) begin n_fail++; $display("FAIL fullpop_level got %0d want %0d", level, DEPTH); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fullpop_ovf got %b want 0", overflow); end
        evt = 1'b0;
        rd_ready = 1'b1;
        got = '0;
        for (int i = 0; i < 8 && rd_valid === 1'b1; i++) begin
            got = rd_data;
            tick();
        end
        rd_ready = 1'b0;
        n_tests++; if (got !== c_last) begin n_fail++; $display("FAIL fullpop_last got %0d want %0d", got, c_last); end
    endtask

    task automatic test_arm();
        do_reset(1'b0);
        arm = 1'b0;
        repeat (2) tick();
        pulse(S + 3, S + 3);
        n_tests++; if (level !== '0) begin n_fail++; $display("FAIL arm_off got level %0d want 0", level); end
        evt = 1'b1;
        repeat (S + 2) tick();
        arm = 1'b1;
        repeat (S + 3) tick();
        n_tests++; if (level !== '0) begin n_fail++; $display("FAIL arm_late got level %0d want 0", level); end
        evt = 1'b0;
        repeat (S + 2) tick();
        pulse(S + 2, S + 3);
        n_tests++; if (level !== LW'(1)) begin n_fail++; $display("FAIL arm_next_edge got level %0d want 1", level); end
        pulse(S + 2, S + 3);
        n_tests++; if (level !== LW'(2)) begin n_fail++; $display("FAIL arm_two got level %0d want 2", level); end
        #2 rst = 1'b0;
        #1;
        n_tests++; if (level !== '0 || rd_valid !== 1'b0 || overflow !== 1'b0)
            begin n_fail++; $display("FAIL async_reset got level %0d valid %b ovf %b want 0 0 0", level, rd_valid, overflow); end
    endtask

    task automatic test_random();
        int hold;
        do_reset(1'b0);
        hold = $urandom_range(S + 1, S + 6);
        for (int i = 0; i < 400; i++) begin
            if (hold == 0) begin evt = ~evt; hold = $urandom_range(S + 1, S + 6); end
            hold--;
            arm      = ($urandom_range(0, 9) != 0);
            rd_ready = ($urandom_range(0, 2) == 0);
            clr_ovf  = ($urandom_range(0, 19) == 0);
            tick();
            n_tests++; if (level !== LW'(mq.size())) begin n_fail++; $display("FAIL rnd_level@%0d got %0d want %0d", i, level, mq.size()); end
            n_tests++; if (rd_valid !== (mq.size() > 0)) begin n_fail++; $display("FAIL rnd_valid@%0d got %b want %b", i, rd_valid, mq.size() > 0); end
            n_tests++; if (overflow !== m_ovf) begin n_fail++; $display("FAIL rnd_ovf@%0d got %b want %b", i, overflow, m_ovf); end
            if (mq.size() > 0) begin
                n_tests++; if (rd_data !== mq[0][N-1:0]) begin n_fail++; $display("FAIL rnd_data@%0d got %0d want %0d", i, rd_data, mq[0][N-1:0]); end
`ifdef COUNT_CAPTURE_BOTH_EDGES_EN
                n_tests++; if (rd_edge !== mq[0][N]) begin n_fail++; $display("FAIL rnd_edge@%0d got %b want %b", i, rd_edge, mq[0][N]); end
`endif
            end
        end
        clr_ovf = 1'b0;
        rd_ready = 1'b0;
    endtask

`ifdef COUNT_CAPTURE_BOTH_EDGES_EN
    task automatic test_both_edges();
        logic [N-1:0] c_rise;
        do_reset(1'b0);
        repeat (2) tick();
        c_rise = count + N'(S);
        pulse(20, S + 3);
        n_tests++; if (level !== LW'(2)) begin n_fail++; $display("FAIL both_level got %0d want 2", level); end
        n_tests++; if (rd_data !== c_rise || rd_edge !== 1'b1) begin n_fail++; $display("FAIL both_rise got %0d/%b want %0d/1", rd_data, rd_edge, c_rise); end
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        n_tests++; if (rd_data !== c_rise + N'(20) || rd_edge !== 1'b0) begin n_fail++; $display("FAIL both_fall got %0d/%b want %0d/0", rd_data, rd_edge, c_rise + N'(20)); end
    endtask
`endif

    initial begin
        test_reset();
        test_latency();
        test_backpressure();
        test_overflow();
        test_full_pop();
        test_arm();
        test_random();
`ifdef COUNT_CAPTURE_BOTH_EDGES_EN
        test_both_edges();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
